icache: RTL and testbench

Direct-mapped, one-word-per-line instruction cache between `ifetch` and `mem_ctrl`. It serves instruction fetches from on-chip storage on a hit. On a miss it forwards a single 32-bit fetch request to `mem_ctrl` and fills the line with the returned word. It honours the pipeline-wide `failed` flush and the global `rdy` pause.

---
 rtl/icache_pkg.sv | 15 +
 rtl/icache_if.sv | 17 +
 rtl/icache_array.sv | 47 ++++
 rtl/icache.sv | 172 +++++++++++++++++
 tb/tb_icache.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: shared constants and FSM state encoding for the instruction cache.
//   AddrLen / InstLen  : fetch address and instruction widths
//   ICacheIndexBits    : default line-index width (2^7 one-word lines)
//   ic_state_e         : ICIdle / ICMiss / ICRet
package icache_pkg;
  localparam int AddrLen         = 32;
  localparam int InstLen         = 32;
  localparam int ICacheIndexBits = 7;

  typedef enum logic [1:0] {
    ICIdle = 2'd0,
    ICMiss = 2'd1,
    ICRet  = 2'd2
  } ic_state_e;
endpackage

// File: rtl/icache_if.sv
// icache_if: one word-fetch channel (address/request out, instruction/enable back).
// Used twice by the cache: as slave towards ifetch and as master towards mem_ctrl.
//   addr    : fetch address (master -> slave)
//   request : level request, held until enable or abort (master -> slave)
//   inst    : returned instruction word (slave -> master)
//   enable  : one-cycle pulse, inst valid while high (slave -> master)
interface icache_if;
  import icache_pkg::*;

  logic [AddrLen-1:0] addr;
  logic               request;
  logic [InstLen-1:0] inst;
  logic               enable;

  modport master (output addr, output request, input inst, input enable);
  modport slave  (input addr, input request, output inst, output enable);
endinterface

// File: rtl/icache_array.sv
// icache_array: valid/tag/data storage for the direct-mapped cache.
//   clk, rst (async active-low, clears valid bits only)
//   rd_idx -> rd_valid, rd_tag, rd_data : combinational read port
//   wr_en, wr_idx, wr_tag, wr_data      : synchronous write port (sets valid)
module icache_array
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int TAG_BITS   = 18 - 2 - INDEX_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_BITS-1:0]   rd_tag,
  output logic [InstLen-1:0]    rd_data,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic [TAG_BITS-1:0]   wr_tag,
  input  logic [InstLen-1:0]    wr_data
);
  localparam int Lines = 1 << INDEX_BITS;

  logic [Lines-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [Lines];
  logic [InstLen-1:0]  data_q [Lines];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset: a line is only ever read through its valid bit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];
endmodule

// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache between ifetch and mem_ctrl.
//   clk, rst (async active-low), rdy (global pause), failed (pipeline flush)
//   if_bus : slave channel from ifetch   (addr, request -> inst, enable)
//   mc_bus : master channel to mem_ctrl  (addr, request -> inst, enable)
//   hit_cnt / miss_cnt : 32-bit statistics, only when ICACHE_STATS_EN is defined
//
// state  | meaning
// ICIdle | waiting for a fetch request; hit lookup done here
// ICMiss | word requested from mem_ctrl, waiting for mc_enable or a flush
// ICRet  | if_enable high for this single cycle, requests ignored
module icache
  import icache_pkg::*;
#(
  parameter int INDEX_BITS = ICacheIndexBits,
  parameter int TAG_BITS   = 18 - 2 - INDEX_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        failed,
  icache_if.slave     if_bus,
  icache_if.master    mc_bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
`endif
);
  ic_state_e             state_q, state_d;
  logic [InstLen-1:0]    if_inst_q, if_inst_d;
  logic                  if_enable_q, if_enable_d;
  logic [AddrLen-1:0]    mc_addr_q, mc_addr_d;
  logic                  mc_request_q, mc_request_d;
  logic [INDEX_BITS-1:0] miss_idx_q, miss_idx_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [InstLen-1:0]    rd_data;
  logic                  hit;
  logic                  fill;
  logic                  hit_take;
  logic                  miss_take;

  assign idx = if_bus.addr[INDEX_BITS+1:2];
  assign tag = if_bus.addr[17:INDEX_BITS+2];
  assign hit = rd_valid && (rd_tag == tag);

  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (fill && rdy),
    .wr_idx   (miss_idx_q),
    .wr_tag   (miss_tag_q),
    .wr_data  (mc_bus.inst)
  );

  always_comb begin
    state_d      = state_q;
    if_inst_d    = if_inst_q;
    if_enable_d  = 1'b0;
    mc_addr_d    = mc_addr_q;
    mc_request_d = mc_request_q;
    miss_idx_d   = miss_idx_q;
    miss_tag_d   = miss_tag_q;
    fill         = 1'b0;
    hit_take     = 1'b0;
    miss_take    = 1'b0;
    case (state_q)
      ICIdle: begin
        if (if_bus.request && !failed) begin
          if (hit) begin
            hit_take    = 1'b1;
            if_inst_d   = rd_data;
            if_enable_d = 1'b1;
            state_d     = ICRet;
          end else begin
            miss_take    = 1'b1;
            mc_addr_d    = if_bus.addr & ~AddrLen'(3);
            mc_request_d = 1'b1;
            miss_idx_d   = idx;
            miss_tag_d   = tag;
            state_d      = ICMiss;
          end
        end
      end
      ICMiss: begin
        if (mc_bus.enable) begin
          // The returned word is always kept, even when the fetch itself is flushed.
          fill         = 1'b1;
          mc_request_d = 1'b0;
          if (!failed) begin
            if_inst_d   = mc_bus.inst;
            if_enable_d = 1'b1;
            state_d     = ICRet;
          end else begin
            state_d = ICIdle;
          end
        end else if (failed) begin
          mc_request_d = 1'b0;
          state_d      = ICIdle;
        end
      end
      ICRet: begin
        state_d = ICIdle;
      end
      default: begin
        state_d = ICIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ICIdle;
      if_inst_q    <= '0;
      if_enable_q  <= 1'b0;
      mc_addr_q    <= '0;
      mc_request_q <= 1'b0;
      miss_idx_q   <= '0;
      miss_tag_q   <= '0;
    end else if (rdy) begin
      state_q      <= state_d;
      if_inst_q    <= if_inst_d;
      if_enable_q  <= if_enable_d;
      mc_addr_q    <= mc_addr_d;
      mc_request_q <= mc_request_d;
      miss_idx_q   <= miss_idx_d;
      miss_tag_q   <= miss_tag_d;
    end
  end

  assign if_bus.inst    = if_inst_q;
  assign if_bus.enable  = if_enable_q;
  assign mc_bus.addr    = mc_addr_q;
  assign mc_bus.request = mc_request_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, hit_take};
    miss_cnt_d = miss_cnt_q + {31'd0, miss_take};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = hit_take ^ miss_take;
`endif
endmodule

// File: tb/tb_icache.sv
module tb_icache;
  logic clk;
  logic rst;
  logic rdy;
  logic failed;

  icache_if if_bus ();
  icache_if mc_bus ();

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
`endif

  icache dut (
    .clk    (clk),
    .rst    (rst),
    .rdy    (rdy),
    .failed (failed),
    .if_bus (if_bus),
    .mc_bus (mc_bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int n_hit    = 0;
  int n_miss   = 0;

  // Reference cache: per line index, the significant word address (bits 17:2) and word held.
  logic [15:0] m_tag  [int];
  logic [31:0] m_data [int];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] w;
    w = a & 32'hFFFF_FFFC;
    if (w == 32'h0000_0100) return 32'h0000_0013;
    return (w ^ 32'hA5A5_0000) + 32'd7;
  endfunction

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 2) % 128);
  endfunction

  function automatic logic model_hit(input logic [31:0] a);
    int l;
    l = line_of(a);
    return m_tag.exists(l) && (m_tag[l] == a[17:2]);
  endfunction

  task automatic model_fill(input logic [31:0] a);
    m_tag[line_of(a)]  = a[17:2];
    m_data[line_of(a)] = mem_word(a);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_stats(input string nm);
`ifdef ICACHE_STATS_EN
    check({nm, " hit_cnt"}, hit_cnt, n_hit);
    check({nm, " miss_cnt"}, miss_cnt, n_miss);
`else
    if (nm.len() < 0) $display("%s", nm);
`endif
  endtask

  // One complete fetch. Everything is driven and sampled on the falling edge.
  task automatic fetch(input logic [31:0] a, input int lat, input logic exp_hit,
                       input logic [31:0] exp_inst, input string nm);
    @(negedge clk);
    if_bus.request = 1'b1;
    if_bus.addr    = a;
    @(negedge clk);
    if (exp_hit) begin
      n_hit++;
      check({nm, " hit if_enable"}, {31'd0, if_bus.enable}, 32'd1);
      check({nm, " hit if_inst"}, if_bus.inst, exp_inst);
      check({nm, " hit mc_request"}, {31'd0, mc_bus.request}, 32'd0);
    end else begin
      n_miss++;
      check({nm, " miss mc_request"}, {31'd0, mc_bus.request}, 32'd1);
      check({nm, " miss mc_addr"}, mc_bus.addr, a & 32'hFFFF_FFFC);
      check({nm, " miss if_enable"}, {31'd0, if_bus.enable}, 32'd0);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk);
        check({nm, " wait mc_request"}, {31'd0, mc_bus.request}, 32'd1);
        check({nm, " wait if_enable"}, {31'd0, if_bus.enable}, 32'd0);
      end
      mc_bus.enable = 1'b1;
      mc_bus.inst   = mem_word(a);
      @(negedge clk);
      mc_bus.enable = 1'b0;
      mc_bus.inst   = $urandom;
      check({nm, " fill if_enable"}, {31'd0, if_bus.enable}, 32'd1);
      check({nm, " fill if_inst"}, if_bus.inst, exp_inst);
      check({nm, " fill mc_request"}, {31'd0, mc_bus.request}, 32'd0);
      model_fill(a);
    end
    if_bus.request = 1'b0;
    if_bus.addr    = $urandom;
    @(negedge clk);
    check({nm, " pulse end"}, {31'd0, if_bus.enable}, 32'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          lat;
    logic        hit;
    logic [31:0] inst;
  } vec_t;

  vec_t tbl [9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a;
    logic        h;
    logic [31:0] e;

    tbl[0] = '{32'h0000_0100, 5, 1'b0, 32'h0000_0013};
    tbl[1] = '{32'h0000_0100, 0, 1'b1, 32'h0000_0013};
    tbl[2] = '{32'h0000_0300, 2, 1'b0, 32'hA5A5_0307};
    tbl[3] = '{32'h0000_0100, 1, 1'b0, 32'h0000_0013};
    tbl[4] = '{32'h0000_0300, 0, 1'b0, 32'hA5A5_0307};
    tbl[5] = '{32'h0000_0104, 3, 1'b0, 32'hA5A5_010B};
    tbl[6] = '{32'h0000_0104, 0, 1'b1, 32'hA5A5_010B};
    tbl[7] = '{32'h0000_0106, 0, 1'b1, 32'hA5A5_010B};
    tbl[8] = '{32'h0004_0104, 0, 1'b1, 32'hA5A5_010B};

    rst            = 1'b0;
    rdy            = 1'b1;
    failed         = 1'b0;
    if_bus.addr    = '0;
    if_bus.request = 1'b0;
    mc_bus.inst    = '0;
    mc_bus.enable  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset if_enable", {31'd0, if_bus.enable}, 32'd0);
    check("reset if_inst", if_bus.inst, 32'd0);
    check("reset mc_request", {31'd0, mc_bus.request}, 32'd0);
    check("reset mc_addr", mc_bus.addr, 32'd0);
    check_stats("reset");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      fetch(tbl[i].addr, tbl[i].lat, tbl[i].hit, tbl[i].inst, $sformatf("vec%0d", i));
      if (i == 1) check_stats("hit after fill");
    end
    check_stats("after table");

    // Flush while waiting on mem_ctrl: no fill, no pulse.
    @(negedge clk);
    if_bus.request = 1'b1;
    if_bus.addr    = 32'h0000_0200;
    n_miss++;
    @(negedge clk);
    check("flush miss mc_request", {31'd0, mc_bus.request}, 32'd1);
    @(negedge clk);
    failed         = 1'b1;
    if_bus.request = 1'b0;
    @(negedge clk);
    failed = 1'b0;
    check("flush mc_request drop", {31'd0, mc_bus.request}, 32'd0);
    check("flush no if_enable", {31'd0, if_bus.enable}, 32'd0);
    @(negedge clk);
    check("flush still no if_enable", {31'd0, if_bus.enable}, 32'd0);
    fetch(32'h0000_0200, 1, 1'b0, mem_word(32'h200), "refetch 0x200");

    // Flush coincident with the fill: line is written, no pulse.
    @(negedge clk);
    if_bus.request = 1'b1;
    if_bus.addr    = 32'h0000_0400;
    n_miss++;
    @(negedge clk);
    check("coinc mc_request", {31'd0, mc_bus.request}, 32'd1);
    mc_bus.enable  = 1'b1;
    mc_bus.inst    = mem_word(32'h400);
    failed         = 1'b1;
    if_bus.request = 1'b0;
    @(negedge clk);
    mc_bus.enable = 1'b0;
    failed        = 1'b0;
    check("coinc no if_enable", {31'd0, if_bus.enable}, 32'd0);
    check("coinc mc_request drop", {31'd0, mc_bus.request}, 32'd0);
    model_fill(32'h400);
    @(negedge clk);
    check("coinc still no if_enable", {31'd0, if_bus.enable}, 32'd0);
    fetch(32'h0000_0400, 0, 1'b1, mem_word(32'h400), "hit 0x400");

    // rdy dropped in RET: pulse held until rdy returns.
    @(negedge clk);
    if_bus.request = 1'b1;
    if_bus.addr    = 32'h0000_0400;
    n_hit++;
    @(negedge clk);
    check("rdy ret if_enable", {31'd0, if_bus.enable}, 32'd1);
    rdy            = 1'b0;
    if_bus.request = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rdy low if_enable held", {31'd0, if_bus.enable}, 32'd1);
      check("rdy low if_inst held", if_bus.inst, mem_word(32'h400));
    end
    rdy = 1'b1;
    @(negedge clk);
    check("rdy back pulse done", {31'd0, if_bus.enable}, 32'd0);
    check_stats("after rdy");

    // Randomized fetches against the reference cache.
    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 2)
          | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 3)) << 18);
      h = model_hit(a);
      e = h ? m_data[line_of(a)] : mem_word(a);
      fetch(a, $urandom_range(0, 4), h, e, $sformatf("rand%0d a=%h", i, a));
    end
    check_stats("after random");

    // Async reset in the middle of a miss.
    @(negedge clk);
    if_bus.request = 1'b1;
    if_bus.addr    = 32'h0000_01F0;
    @(negedge clk);
    check("rst miss mc_request", {31'd0, mc_bus.request}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("rst async mc_request", {31'd0, mc_bus.request}, 32'd0);
    check("rst async if_enable", {31'd0, if_bus.enable}, 32'd0);
    check("rst async mc_addr", mc_bus.addr, 32'd0);
    m_tag.delete();
    m_data.delete();
    n_hit          = 0;
    n_miss         = 0;
    if_bus.request = 1'b0;
    check_stats("rst async");
    @(negedge clk);
    rst           = 1'b1;
    mc_bus.enable = 1'b1;
    mc_bus.inst   = 32'hDEAD_BEEF;
    @(negedge clk);
    mc_bus.enable = 1'b0;
    check("stale mc_enable ignored", {31'd0, if_bus.enable}, 32'd0);
    check("stale mc_request", {31'd0, mc_bus.request}, 32'd0);
    fetch(32'h0000_0400, 1, 1'b0, mem_word(32'h400), "post-rst 0x400");
    fetch(32'h0000_0100, 0, 1'b0, 32'h0000_0013, "post-rst 0x100");
    fetch(32'h0000_0100, 0, 1'b1, 32'h0000_0013, "post-rst hit 0x100");
    check_stats("final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
